// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit holding architectural HI/LO with modelled multi-cycle latency.
// Optional MADD/MADDU accumulate ops are enabled by defining MDU_MADD_EN.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDU_op,
    input  logic        Start,
    input  logic        Req,
    output logic        Busy,
    output logic [31:0] MDU_result
);
    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_MFHI  = 4'b0101;
    localparam logic [3:0] OP_MFLO  = 4'b0110;
    localparam logic [3:0] OP_MTHI  = 4'b0111;
    localparam logic [3:0] OP_MTLO  = 4'b1000;
    localparam logic [3:0] OP_MADD  = 4'b1001;
    localparam logic [3:0] OP_MADDU = 4'b1010;

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [3:0]      r_op;
    logic [31:0]     r_a, r_b, r_hi, r_lo;

    logic            w_is_mul, w_is_div, w_accept;
    logic [63:0]     w_sprod, w_uprod, w_acc;
    logic [31:0]     w_a_abs, w_b_abs, w_div_b, w_uq, w_ur, w_sq, w_sr;
    logic [31:0]     w_duq, w_dur;

`ifdef MDU_MADD_EN
    assign w_is_mul = (MDU_op == OP_MULT) || (MDU_op == OP_MULTU) ||
                      (MDU_op == OP_MADD) || (MDU_op == OP_MADDU);
`else
    assign w_is_mul = (MDU_op == OP_MULT) || (MDU_op == OP_MULTU);
`endif
    assign w_is_div = (MDU_op == OP_DIV) || (MDU_op == OP_DIVU);
    assign w_accept = Start && !Req && (r_state == S_IDLE) && (w_is_mul || w_is_div);

    assign w_sprod = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
    assign w_uprod = {32'b0, r_a} * {32'b0, r_b};
    assign w_acc   = (r_op == OP_MADD) ? ({r_hi, r_lo} + w_sprod) : ({r_hi, r_lo} + w_uprod);

    // Signed divide through magnitudes: avoids the -2^31 / -1 overflow and gives truncation toward zero.
    assign w_a_abs = r_a[31] ? (~r_a + 32'd1) : r_a;
    assign w_b_abs = r_b[31] ? (~r_b + 32'd1) : r_b;
    assign w_div_b = (w_b_abs == 32'd0) ? 32'd1 : w_b_abs;
    assign w_uq    = w_a_abs / w_div_b;
    assign w_ur    = w_a_abs % w_div_b;
    assign w_sq    = (r_a[31] ^ r_b[31]) ? (~w_uq + 32'd1) : w_uq;
    assign w_sr    = r_a[31] ? (~w_ur + 32'd1) : w_ur;
    assign w_duq   = r_a / ((r_b == 32'd0) ? 32'd1 : r_b);
    assign w_dur   = r_a % ((r_b == 32'd0) ? 32'd1 : r_b);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_RUN;
                        r_op    <= MDU_op;
                        r_a     <= A;
                        r_b     <= B;
                        r_cnt   <= w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    end else if (!Req && MDU_op == OP_MTHI) begin
                        r_hi <= A;
                    end else if (!Req && MDU_op == OP_MTLO) begin
                        r_lo <= A;
                    end
                end
                S_RUN: begin
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        case (r_op)
                            OP_MULT:  {r_hi, r_lo} <= w_sprod;
                            OP_MULTU: {r_hi, r_lo} <= w_uprod;
                            OP_DIV:   if (r_b != 32'd0) begin r_lo <= w_sq;  r_hi <= w_sr;  end
                            OP_DIVU:  if (r_b != 32'd0) begin r_lo <= w_duq; r_hi <= w_dur; end
                            OP_MADD, OP_MADDU: {r_hi, r_lo} <= w_acc;
                            default: ;
                        endcase
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Busy = (r_state == S_RUN);

    always_comb begin
        MDU_result = 32'd0;
        if (MDU_op == OP_MFHI)      MDU_result = r_hi;
        else if (MDU_op == OP_MFLO) MDU_result = r_lo;
    end
endmodule
